// File: rtl/clk_pkg.sv
// rtl/clk_pkg.sv - BCD types, field limits and digit arithmetic for the clock datapath
package clk_pkg;

   typedef logic [3:0] bcd_digit_t;
   typedef logic [7:0] bcd_pair_t;

   localparam int SEC_MAX  = 59;
   localparam int MIN_MAX  = 59;
   localparam int HR24_MAX = 23;
   localparam int HR12_MIN = 1;
   localparam int HR12_MAX = 12;

   function automatic bcd_pair_t to_bcd(input int n);
      bcd_digit_t tens;
      bcd_digit_t ones;
      tens = bcd_digit_t'((n / 10) % 10);
      ones = bcd_digit_t'(n % 10);
      return {tens, ones};
   endfunction

   function automatic logic bcd_valid(input bcd_pair_t p);
      return (p[7:4] <= 4'd9) && (p[3:0] <= 4'd9);
   endfunction

   // Legal BCD pairs order the same way as their decimal values.
   function automatic logic bcd_in_range(input bcd_pair_t p, input bcd_pair_t lo, input bcd_pair_t hi);
      return bcd_valid(p) && (p >= lo) && (p <= hi);
   endfunction

   function automatic bcd_pair_t bcd_inc(input bcd_pair_t p, input bcd_pair_t lo, input bcd_pair_t hi);
      if (p == hi)
         return lo;
      if (p[3:0] == 4'd9)
         return {p[7:4] + 4'd1, 4'd0};
      return {p[7:4], p[3:0] + 4'd1};
   endfunction

   function automatic bcd_pair_t bcd_dec(input bcd_pair_t p, input bcd_pair_t lo, input bcd_pair_t hi);
      if (p == lo)
         return hi;
      if (p[3:0] == 4'd0)
         return {p[7:4] - 4'd1, 4'd9};
      return {p[7:4], p[3:0] - 4'd1};
   endfunction

endpackage

// File: rtl/key_edge_sync.sv
// rtl/key_edge_sync.sv - multi-flop synchroniser with a one-cycle rising-edge pulse
module key_edge_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic key,
   output logic pulse
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   last_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
         last_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], key};
         last_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign pulse = sync_q[SYNC_STAGES-1] & ~last_q;

endmodule

// File: rtl/bcd_mod_counter.sv
// rtl/bcd_mod_counter.sv - two-digit BCD modulo counter with chained carry, key adjust and load
module bcd_mod_counter
   import clk_pkg::*;
#(
   parameter int MIN_VALUE   = 0,
   parameter int MAX_VALUE   = 23,
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       carry_in,
   input  logic       key_inc,
   input  logic       key_dec,
   input  logic       load,
   input  logic [7:0] load_val,
   output logic [7:0] value,
   output logic       carry_out,
   output logic       load_err
);

   localparam bcd_pair_t MIN_BCD = to_bcd(MIN_VALUE);
   localparam bcd_pair_t MAX_BCD = to_bcd(MAX_VALUE);

   logic inc_pulse;
   logic dec_pulse;
   logic pend_inc;
   logic pend_dec;
   logic inc_evt;
   logic dec_evt;
   logic want_inc;
   logic want_dec;
   logic tick;
   logic load_ok;

   key_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_inc (
      .clk   (clk),
      .rst   (rst),
      .key   (key_inc),
      .pulse (inc_pulse)
   );

   key_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_dec (
      .clk   (clk),
      .rst   (rst),
      .key   (key_dec),
      .pulse (dec_pulse)
   );

   assign inc_evt  = en & inc_pulse;
   assign dec_evt  = en & dec_pulse;
   assign tick     = en & carry_in;
   assign want_inc = pend_inc | inc_evt;
   assign want_dec = pend_dec | dec_evt;
   assign load_ok  = bcd_in_range(load_val, MIN_BCD, MAX_BCD);

   // Load and tick own the cycle; a key edge arriving then is parked until a free cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         value     <= MIN_BCD;
         carry_out <= 1'b0;
         load_err  <= 1'b0;
         pend_inc  <= 1'b0;
         pend_dec  <= 1'b0;
      end else begin
         carry_out <= 1'b0;
         load_err  <= 1'b0;
         if (load) begin
            if (load_ok)
               value <= load_val;
            else
               load_err <= 1'b1;
            pend_inc <= inc_evt;
            pend_dec <= dec_evt;
         end else if (tick) begin
            value     <= bcd_inc(value, MIN_BCD, MAX_BCD);
            carry_out <= (value == MAX_BCD);
            pend_inc  <= want_inc;
            pend_dec  <= want_dec;
         end else if (en) begin
            if (want_inc && !want_dec)
               value <= bcd_inc(value, MIN_BCD, MAX_BCD);
            else if (want_dec && !want_inc)
               value <= bcd_dec(value, MIN_BCD, MAX_BCD);
            pend_inc <= 1'b0;
            pend_dec <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_bcd_mod_counter.sv
// tb/tb_bcd_mod_counter.sv - three field configurations driven together against a decimal model
module tb_bcd_mod_counter;

   localparam int NDUT = 3;
   localparam int S    = 2;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic       carry_in;
   logic       key_inc;
   logic       key_dec;
   logic       load;
   logic [7:0] load_val;
   logic [7:0] value     [NDUT];
   logic       carry_out [NDUT];
   logic       load_err  [NDUT];

   int total = 0;
   int bad   = 0;

   int mv  [NDUT];
   bit mpi [NDUT];
   bit mpd [NDUT];
   bit mco [NDUT];
   bit mle [NDUT];
   bit qi  [$];
   bit qd  [$];

   always #5 clk = ~clk;

   bcd_mod_counter #(.MIN_VALUE(0), .MAX_VALUE(23), .SYNC_STAGES(S)) u_hr24 (
      .clk(clk), .rst(rst), .en(en), .carry_in(carry_in), .key_inc(key_inc), .key_dec(key_dec),
      .load(load), .load_val(load_val), .value(value[0]), .carry_out(carry_out[0]), .load_err(load_err[0]));

   bcd_mod_counter #(.MIN_VALUE(0), .MAX_VALUE(59), .SYNC_STAGES(S)) u_min (
      .clk(clk), .rst(rst), .en(en), .carry_in(carry_in), .key_inc(key_inc), .key_dec(key_dec),
      .load(load), .load_val(load_val), .value(value[1]), .carry_out(carry_out[1]), .load_err(load_err[1]));

   bcd_mod_counter #(.MIN_VALUE(1), .MAX_VALUE(12), .SYNC_STAGES(S)) u_hr12 (
      .clk(clk), .rst(rst), .en(en), .carry_in(carry_in), .key_inc(key_inc), .key_dec(key_dec),
      .load(load), .load_val(load_val), .value(value[2]), .carry_out(carry_out[2]), .load_err(load_err[2]));

   function automatic int lo_of(input int d);
      return (d == 2) ? 1 : 0;
   endfunction

   function automatic int hi_of(input int d);
      return (d == 0) ? 23 : (d == 1) ? 59 : 12;
   endfunction

   function automatic logic [7:0] enc(input int n);
      return {4'(n / 10), 4'(n % 10)};
   endfunction

   // Pin level S clock edges ago high, and the one before it low.
   function automatic bit key_event(input bit q[$]);
      return q[q.size()-S] & ~q[q.size()-S-1];
   endfunction

   task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < NDUT; d++) begin
         mv[d]  = lo_of(d);
         mpi[d] = 0;
         mpd[d] = 0;
         mco[d] = 0;
         mle[d] = 0;
      end
      qi.delete();
      qd.delete();
      repeat (S + 1) begin
         qi.push_back(1'b0);
         qd.push_back(1'b0);
      end
   endtask

   task automatic model_step();
      bit ie, de, a, b, ok;
      int t, o, n;
      ie = en && key_event(qi);
      de = en && key_event(qd);
      qi.push_back(key_inc);
      qd.push_back(key_dec);
      if (qi.size() > S + 3) void'(qi.pop_front());
      if (qd.size() > S + 3) void'(qd.pop_front());
      t = int'(load_val[7:4]);
      o = int'(load_val[3:0]);
      n = t * 10 + o;
      for (int d = 0; d < NDUT; d++) begin
         mco[d] = 0;
         mle[d] = 0;
         if (load) begin
            ok = (t <= 9) && (o <= 9) && (n >= lo_of(d)) && (n <= hi_of(d));
            if (ok) mv[d] = n;
            else    mle[d] = 1;
            mpi[d] = ie;
            mpd[d] = de;
         end else if (en && carry_in) begin
            if (mv[d] == hi_of(d)) begin
               mv[d]  = lo_of(d);
               mco[d] = 1;
            end else begin
               mv[d] = mv[d] + 1;
            end
            mpi[d] = mpi[d] | ie;
            mpd[d] = mpd[d] | de;
         end else if (en) begin
            a = mpi[d] | ie;
            b = mpd[d] | de;
            if (a && !b) mv[d] = (mv[d] == hi_of(d)) ? lo_of(d) : mv[d] + 1;
            if (b && !a) mv[d] = (mv[d] == lo_of(d)) ? hi_of(d) : mv[d] - 1;
            mpi[d] = 0;
            mpd[d] = 0;
         end
      end
   endtask

   task automatic compare_all();
      for (int d = 0; d < NDUT; d++) begin
         check_eq($sformatf("value%0d", d), value[d], enc(mv[d]));
         check_eq($sformatf("carry_out%0d", d), {7'd0, carry_out[d]}, {7'd0, mco[d]});
         check_eq($sformatf("load_err%0d", d), {7'd0, load_err[d]}, {7'd0, mle[d]});
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
      compare_all();
   endtask

   task automatic do_load(input logic [7:0] v);
      load     = 1'b1;
      load_val = v;
      cycle();
      load     = 1'b0;
   endtask

   initial begin
      rst = 1'b1; en = 1'b1; carry_in = 1'b0; key_inc = 1'b0; key_dec = 1'b0;
      load = 1'b0; load_val = 8'h00;
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      model_reset();
      check_eq("rst_val24", value[0], 8'h00);
      check_eq("rst_val12", value[2], 8'h01);
      check_eq("rst_co", {7'd0, carry_out[0]}, 8'h00);
      check_eq("rst_le", {7'd0, load_err[0]}, 8'h00);

      carry_in = 1'b1;
      repeat (23) cycle();
      check_eq("tick23_val", value[0], 8'h23);
      check_eq("tick23_co", {7'd0, carry_out[0]}, 8'h00);
      cycle();
      check_eq("wrap_val", value[0], 8'h00);
      check_eq("wrap_co", {7'd0, carry_out[0]}, 8'h01);
      carry_in = 1'b0;
      cycle();
      check_eq("wrap_co_once", {7'd0, carry_out[0]}, 8'h00);

      do_load(8'h09);
      carry_in = 1'b1; cycle(); carry_in = 1'b0;
      check_eq("roll_09_10", value[1], 8'h10);
      do_load(8'h59);
      carry_in = 1'b1; cycle(); carry_in = 1'b0;
      check_eq("roll_59_00", value[1], 8'h00);
      check_eq("roll_59_co", {7'd0, carry_out[1]}, 8'h01);

      do_load(8'h01);
      key_dec = 1'b1; cycle(); key_dec = 1'b0;
      repeat (3) cycle();
      check_eq("hr12_dec_wrap", value[2], 8'h12);
      check_eq("hr12_dec_co", {7'd0, carry_out[2]}, 8'h00);
      carry_in = 1'b1; cycle(); carry_in = 1'b0;
      check_eq("hr12_tick_wrap", value[2], 8'h01);
      check_eq("hr12_tick_co", {7'd0, carry_out[2]}, 8'h01);

      do_load(8'h05);
      key_inc = 1'b1;
      cycle(); cycle();
      carry_in = 1'b1; cycle(); carry_in = 1'b0;
      check_eq("collide_tick", value[0], 8'h06);
      cycle();
      check_eq("collide_key", value[0], 8'h07);
      key_inc = 1'b0;
      repeat (2) cycle();
      key_inc = 1'b1; key_dec = 1'b1;
      repeat (4) cycle();
      check_eq("cancel", value[0], 8'h07);
      key_inc = 1'b0; key_dec = 1'b0;
      repeat (2) cycle();

      load = 1'b1;
      load_val = 8'h1A; cycle();
      check_eq("bad_1a_val", value[0], 8'h07);
      check_eq("bad_1a_err", {7'd0, load_err[0]}, 8'h01);
      load_val = 8'h24; cycle();
      check_eq("bad_24_val", value[0], 8'h07);
      check_eq("bad_24_err", {7'd0, load_err[0]}, 8'h01);
      check_eq("ok_24_min", value[1], 8'h24);
      load = 1'b0; cycle();
      check_eq("err_once", {7'd0, load_err[0]}, 8'h00);
      en = 1'b0;
      do_load(8'h15);
      check_eq("load_en0", value[0], 8'h15);

      carry_in = 1'b1; cycle(); carry_in = 1'b0;
      check_eq("en0_tick", value[0], 8'h15);
      en = 1'b1;
      repeat (2) cycle();
      check_eq("en0_no_defer", value[0], 8'h15);

      key_inc = 1'b1;
      cycle(); cycle();
      carry_in = 1'b1; key_inc = 1'b0;
      cycle();
      carry_in = 1'b0;
      rst = 1'b1;
      model_reset();
      #2;
      check_eq("async_rst24", value[0], 8'h00);
      check_eq("async_rst12", value[2], 8'h01);
      #2 rst = 1'b0;
      repeat (4) cycle();
      check_eq("no_pending", value[0], 8'h00);

      repeat (3000) begin
         en       = ($urandom_range(0, 99) < 85);
         carry_in = ($urandom_range(0, 99) < 30);
         load     = ($urandom_range(0, 99) < 5);
         load_val = ($urandom_range(0, 1) == 1) ? enc(int'($urandom_range(0, 99))) : 8'($urandom);
         if ($urandom_range(0, 99) < 15) key_inc = ~key_inc;
         if ($urandom_range(0, 99) < 15) key_dec = ~key_dec;
         if ($urandom_range(0, 999) < 3) begin
            rst = 1'b1;
            model_reset();
            #2 rst = 1'b0;
         end
         cycle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
